// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the data-memory/peripheral port arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned ADDR_W           = 32;
    localparam int unsigned DATA_W           = 32;
    localparam int unsigned STARVE_W         = 3;
    localparam int unsigned LOCK_W           = 5;
    localparam int unsigned STAT_W           = 32;
    localparam int unsigned STARVE_LIMIT_DEF = 4;
    localparam int unsigned LOCK_MAX_DEF     = 16;
    localparam int unsigned PERIPH_BIT_DEF   = 30;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CPU_OWN  = 2'd1,
        ST_DMA_OWN  = 2'd2,
        ST_DMA_LOCK = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] v);
        return (v == '1) ? v : v + STARVE_W'(1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_addr_decode.sv
// RAM vs peripheral select and read-data mux for the shared port.
module mem_bus_arbiter_addr_decode
    import mem_bus_arbiter_pkg::*;
(
    input  logic              access_i,
    input  logic              periph_bit_i,
    input  logic [DATA_W-1:0] ram_rdata_i,
    input  logic [DATA_W-1:0] per_rdata_i,
    output logic              ram_sel_o,
    output logic              per_sel_o,
    output logic [DATA_W-1:0] rdata_o
);

    assign ram_sel_o = access_i & ~periph_bit_i;
    assign per_sel_o = access_i &  periph_bit_i;
    assign rdata_o   = per_sel_o ? per_rdata_i :
                       ram_sel_o ? ram_rdata_i : '0;

endmodule

// File: rtl/mem_bus_arbiter.sv
// CPU MEM-stage / DMA arbiter for the single data port; 0-cycle grant, starvation and lock limits.
// Optional MEM_ARB_STATS_EN adds stall-cycle and DMA-grant counters.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int unsigned LOCK_MAX     = LOCK_MAX_DEF,
    parameter int unsigned PERIPH_BIT   = PERIPH_BIT_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cpu_rd_i,
    input  logic              cpu_wr_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic              dma_lock_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_wdata_i,
    output logic              dma_gnt_o,
    output logic [DATA_W-1:0] dma_rdata_o,
    output logic              mem_rd_o,
    output logic              mem_wr_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              ram_sel_o,
    output logic              per_sel_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    input  logic [DATA_W-1:0] per_rdata_i
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_stall_cnt_o,
    output logic [STAT_W-1:0] stat_dma_cnt_o
`endif
);

    arb_state_e          state_q, state_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic                cpu_req, gnt_cpu, gnt_dma, forced_slot;
    bus_req_t            cpu_bus, dma_bus, bus;
    logic [DATA_W-1:0]   rdata;

    assign cpu_req = cpu_rd_i | cpu_wr_i;
    assign cpu_bus = '{rd: cpu_rd_i & ~cpu_wr_i, wr: cpu_wr_i, addr: cpu_addr_i, wdata: cpu_wdata_i};
    assign dma_bus = '{rd: ~dma_we_i, wr: dma_we_i, addr: dma_addr_i, wdata: dma_wdata_i};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
            lock_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end

    always_comb begin
        gnt_cpu      = 1'b0;
        gnt_dma      = 1'b0;
        forced_slot  = 1'b0;
        state_d      = ST_IDLE;
        starve_cnt_d = '0;
        lock_cnt_d   = '0;
        if (!reset_i) begin
            if (state_q == ST_DMA_LOCK && dma_req_i && lock_cnt_q < LOCK_W'(LOCK_MAX)) begin
                gnt_dma = 1'b1;
            end else if (cpu_req && (starve_cnt_q < STARVE_W'(STARVE_LIMIT) || !dma_req_i)) begin
                gnt_cpu     = 1'b1;
                forced_slot = (state_q == ST_DMA_LOCK) && dma_req_i;
            end else if (dma_req_i) begin
                gnt_dma = 1'b1;
            end
        end

        if (gnt_dma) begin
            state_d = dma_lock_i ? ST_DMA_LOCK : ST_DMA_OWN;
        end else if (gnt_cpu) begin
            state_d = ST_CPU_OWN;
        end

        // A forced slot after a capped burst gives the CPU exactly one grant, then DMA resumes.
        if (forced_slot) begin
            starve_cnt_d = STARVE_W'(STARVE_LIMIT);
        end else if (gnt_cpu && dma_req_i) begin
            starve_cnt_d = starve_inc(starve_cnt_q);
        end

        // The entry grant counts as the first word of the burst.
        if (gnt_dma && dma_lock_i) begin
            lock_cnt_d = (state_q == ST_DMA_LOCK && lock_cnt_q < LOCK_W'(LOCK_MAX)) ?
                         lock_cnt_q + LOCK_W'(1) : LOCK_W'(1);
        end
    end

    assign bus = gnt_dma ? dma_bus : (gnt_cpu ? cpu_bus : '0);

    assign mem_rd_o    = bus.rd;
    assign mem_wr_o    = bus.wr;
    assign mem_addr_o  = bus.addr;
    assign mem_wdata_o = bus.wdata;
    assign dma_gnt_o   = gnt_dma;
    assign cpu_stall_o = cpu_req & ~gnt_cpu & ~reset_i;
    assign cpu_rdata_o = gnt_cpu ? rdata : '0;
    assign dma_rdata_o = gnt_dma ? rdata : '0;

    mem_bus_arbiter_addr_decode u_decode (
        .access_i     (gnt_cpu | gnt_dma),
        .periph_bit_i (bus.addr[PERIPH_BIT]),
        .ram_rdata_i  (ram_rdata_i),
        .per_rdata_i  (per_rdata_i),
        .ram_sel_o    (ram_sel_o),
        .per_sel_o    (per_sel_o),
        .rdata_o      (rdata)
    );

`ifdef MEM_ARB_STATS_EN
    logic [STAT_W-1:0] stat_stall_cnt_q, stat_dma_cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stat_stall_cnt_q <= '0;
            stat_dma_cnt_q   <= '0;
        end else begin
            stat_stall_cnt_q <= stat_stall_cnt_q + STAT_W'(cpu_stall_o);
            stat_dma_cnt_q   <= stat_dma_cnt_q + STAT_W'(gnt_dma);
        end
    end

    assign stat_stall_cnt_o = stat_stall_cnt_q;
    assign stat_dma_cnt_o   = stat_dma_cnt_q;
`endif

endmodule
